life_counter: RTL
=================

LIFE_COUNTER -- requirements
Module: life_counter

Interface
REQ-001 SHALL have parameter INIT_LIVES, default 3, lives loaded at reset/restart (1..9).
REQ-002 SHALL have parameter MAX_LIVES, default 9, saturation ceiling (INIT_LIVES..9).
REQ-003 SHALL have parameter PAUSE_FRAMES, default 60, frame ticks spent in PAUSE after a lost ball (1..255).
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 SHALL have port ball_lost  input  1  one-cycle pulse, ball passed the paddle.
REQ-008 SHALL have port life_gain  input  1  one-cycle pulse, bonus life earned.
REQ-009 SHALL have port restart  input  1  one-cycle pulse, start a new game.
REQ-010 SHALL have port regis  output  4  digit code for the text overlay, low nibble of font char address.
REQ-011 SHALL have port sel_text  output  3  font page for the text overlay, high bits of font char address.
REQ-012 SHALL have port serve_en  output  1  ball may be launched.
REQ-013 SHALL have port game_over  output  1  no lives left.

Function
REQ-014 SHALL hold a 4-bit lives register and a 3-state FSM: PLAY, PAUSE, OVER.
REQ-015 SHALL sample all pulse inputs on the rising clk edge; all outputs registered, reflecting that edge's update (no extra latency).
REQ-016 restart SHALL have top priority in every state: lives=INIT_LIVES, state=PLAY, pause and blink counters cleared.
REQ-017 PLAY, life_gain only: lives=min(lives+1, MAX_LIVES), stay PLAY.
REQ-018 PLAY, ball_lost: next lives = min(lives+g, MAX_LIVES) - 1, g=life_gain same cycle; result 0 -> OVER, else -> PAUSE with pause counter = PAUSE_FRAMES-1.
REQ-019 PAUSE: ball_lost ignored; life_gain applied per REQ-017 saturation; pause counter decrements on frame_tick; frame_tick while counter==0 -> PLAY.
REQ-020 OVER: ball_lost and life_gain ignored; lives held at 0; only restart exits.
REQ-021 serve_en SHALL be 1 only in PLAY; game_over SHALL be 1 only in OVER.
REQ-022 Displayed digit: sel_text=3'b011, regis=lives (ASCII '0'..'9').
REQ-023 Blanked digit: sel_text=3'b010, regis=4'h0 (ASCII space).
REQ-024 A 4-bit blink counter SHALL clear on entering PAUSE and increment on frame_tick in PAUSE; digit blanked while its bit 3 is 1, shown otherwise and in PLAY/OVER.
REQ-025 Lives SHALL never underflow below 0 nor exceed MAX_LIVES under any input combination.

Reset
REQ-026 reset asserted SHALL asynchronously force: state=PLAY, lives=INIT_LIVES, counters=0, regis=INIT_LIVES, sel_text=3'b011, serve_en=1, game_over=0.
REQ-027 reset mid-PAUSE or mid-OVER SHALL discard all progress; pulses coincident with reset deassertion edge are ignored.

Configuration
REQ-028 Macro LIFE_BLINK_EN defined: blink counter and blanking per REQ-023/REQ-024 compiled in.
REQ-029 LIFE_BLINK_EN undefined: no blink counter; digit always shown per REQ-022 in all states; all other behaviour identical.

Verification
REQ-030 Reset, INIT_LIVES=3: regis=3, sel_text=3'b011, serve_en=1, game_over=0.
REQ-031 ball_lost in PLAY with lives=3 -> lives=2, serve_en=0; after 60 frame_ticks -> PLAY, serve_en=1.
REQ-032 Three ball_lost pulses, each after PAUSE ends -> third gives regis=0, game_over=1; further life_gain keeps regis=0; restart -> regis=3, PLAY.
REQ-033 lives=9, life_gain x2 -> regis=9; ball_lost+life_gain same cycle at lives=9 -> regis=8, PAUSE.
REQ-034 LIFE_BLINK_EN defined, in PAUSE: frame ticks 0-7 sel_text=3'b011, 8-15 sel_text=3'b010 regis=0; undefined: sel_text=3'b011 throughout.
REQ-035 reset asserted mid-PAUSE between clock edges -> outputs immediately at REQ-026 values without waiting for clk.

Source files
------------

// File: rtl/life_counter.sv
// Lives counter with PLAY/PAUSE/OVER flow and a registered font-address digit overlay.
// Optional digit blinking during PAUSE is compiled in when LIFE_BLINK_EN is defined.
module life_counter #(
   parameter int unsigned INIT_LIVES   = 3,
   parameter int unsigned MAX_LIVES    = 9,
   parameter int unsigned PAUSE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       ball_lost,
   input  logic       life_gain,
   input  logic       restart,
   output logic [3:0] regis,
   output logic [2:0] sel_text,
   output logic       serve_en,
   output logic       game_over
);

   typedef enum logic [1:0] {
      ST_PLAY  = 2'd0,
      ST_PAUSE = 2'd1,
      ST_OVER  = 2'd2
   } state_t;

   localparam logic [3:0] INIT_L     = 4'(INIT_LIVES);
   localparam logic [3:0] MAX_L      = 4'(MAX_LIVES);
   localparam logic [7:0] PAUSE_LOAD = 8'(PAUSE_FRAMES - 1);
   localparam logic [2:0] PAGE_DIGIT = 3'b011;
   localparam logic [2:0] PAGE_SPACE = 3'b010;

   state_t     state_q, state_d;
   logic [3:0] lives_q, lives_d;
   logic [7:0] pause_q, pause_d;
   logic [3:0] gained;
   logic [3:0] after_gain;
   logic       blank_d;
   logic [3:0] regis_d;
   logic [2:0] sel_d;
   logic       serve_d;
   logic       over_d;

`ifdef LIFE_BLINK_EN
   logic [3:0] blink_q, blink_d;
`endif

   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      pause_d    = pause_q;
`ifdef LIFE_BLINK_EN
      blink_d    = blink_q;
`endif
      gained     = (lives_q >= MAX_L) ? MAX_L : lives_q + 4'd1;
      after_gain = life_gain ? gained : lives_q;

      if (restart) begin
         state_d = ST_PLAY;
         lives_d = INIT_L;
         pause_d = '0;
`ifdef LIFE_BLINK_EN
         blink_d = '0;
`endif
      end else begin
         unique case (state_q)
            ST_PLAY: begin
               if (ball_lost) begin
                  // Same-cycle bonus is credited before the loss is charged.
                  if (after_gain <= 4'd1) begin
                     lives_d = '0;
                     state_d = ST_OVER;
                  end else begin
                     lives_d = after_gain - 4'd1;
                     state_d = ST_PAUSE;
                     pause_d = PAUSE_LOAD;
`ifdef LIFE_BLINK_EN
                     blink_d = '0;
`endif
                  end
               end else begin
                  lives_d = after_gain;
               end
            end
            ST_PAUSE: begin
               lives_d = after_gain;
               if (frame_tick) begin
                  if (pause_q == '0) state_d = ST_PLAY;
                  else               pause_d = pause_q - 8'd1;
`ifdef LIFE_BLINK_EN
                  blink_d = blink_q + 4'd1;
`endif
               end
            end
            ST_OVER: begin
               lives_d = '0;
            end
            default: begin
               state_d = ST_PLAY;
               lives_d = INIT_L;
               pause_d = '0;
            end
         endcase
      end

      // Outputs are derived from next-state values so they reflect this edge's update.
`ifdef LIFE_BLINK_EN
      blank_d = (state_d == ST_PAUSE) && blink_d[3];
`else
      blank_d = 1'b0;
`endif
      regis_d = blank_d ? 4'h0 : lives_d;
      sel_d   = blank_d ? PAGE_SPACE : PAGE_DIGIT;
      serve_d = (state_d == ST_PLAY);
      over_d  = (state_d == ST_OVER);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_PLAY;
         lives_q   <= INIT_L;
         pause_q   <= '0;
         regis     <= INIT_L;
         sel_text  <= PAGE_DIGIT;
         serve_en  <= 1'b1;
         game_over <= 1'b0;
      end else begin
         state_q   <= state_d;
         lives_q   <= lives_d;
         pause_q   <= pause_d;
         regis     <= regis_d;
         sel_text  <= sel_d;
         serve_en  <= serve_d;
         game_over <= over_d;
      end
   end

`ifdef LIFE_BLINK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) blink_q <= '0;
      else       blink_q <= blink_d;
   end
`endif

endmodule
